// File: rtl/printer_pkg.sv
// rtl/printer_pkg.sv - shared state encoding and ASCII constants for packet_printer
package printer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    LO_NIB,
    CR,
    LF,
    FIN
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

endpackage

// File: rtl/nib2hex.sv
// rtl/nib2hex.sv - combinational nibble to uppercase ASCII hex character
module nib2hex
  import printer_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nib_i < 4'd10) begin
      ascii_o = ASCII_0 + {4'h0, nib_i};
    end else begin
      ascii_o = ASCII_A + {4'h0, nib_i} - 8'd10;
    end
  end

endmodule

// File: rtl/packet_printer.sv
// rtl/packet_printer.sv - latches a packet and streams it MSB-byte-first as raw or hex chars
module packet_printer
  import printer_pkg::*;
#(
  parameter int PACKET_BYTES = 22,
  parameter int HEX_MODE     = 1,
  parameter int APPEND_CRLF  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [8*PACKET_BYTES-1:0] packet,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                tx_byte,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int PW    = 8 * PACKET_BYTES;
  localparam int IDX_W = $clog2(PACKET_BYTES + 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PACKET_BYTES - 1);
  localparam state_t END_ST = (APPEND_CRLF != 0) ? CR : FIN;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PW-1:0]     shadow_q, shadow_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs;
  logic [7:0]        cur_byte;
  logic [3:0]        nib_sel;
  logic [7:0]        hex_char;

  assign hs = tx_valid_q & tx_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PAYLOAD;
          idx_d    = IDX_TOP;
          shadow_d = packet;
        end
      end
      PAYLOAD: begin
        if (hs) begin
          if (HEX_MODE != 0) begin
            state_d = LO_NIB;
          end else if (idx_q == '0) begin
            state_d = END_ST;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      LO_NIB: begin
        if (hs) begin
          if (idx_q == '0) begin
            state_d = END_ST;
          end else begin
            state_d = PAYLOAD;
            idx_d   = idx_q - 1'b1;
          end
        end
      end
      CR:      if (hs) state_d = LF;
      LF:      if (hs) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Character is derived from next state, so a stalled beat recomputes the same value.
  assign cur_byte = 8'(shadow_d >> {idx_d, 3'b000});
  assign nib_sel  = (state_d == LO_NIB) ? cur_byte[3:0] : cur_byte[7:4];

  nib2hex u_nib2hex (
    .nib_i   (nib_sel),
    .ascii_o (hex_char)
  );

  always_comb begin
    tx_byte_d  = 8'h00;
    tx_valid_d = 1'b1;
    case (state_d)
      PAYLOAD: tx_byte_d = (HEX_MODE != 0) ? hex_char : cur_byte;
      LO_NIB:  tx_byte_d = hex_char;
      CR:      tx_byte_d = ASCII_CR;
      LF:      tx_byte_d = ASCII_LF;
      default: tx_valid_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_packet_printer.sv
// tb/tb_packet_printer.sv - directed vector bench for raw, hex+CRLF and default packet_printer configs
module tb_packet_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_a, start_b, start_c;
  logic         rdy_a, rdy_b, rdy_c;
  logic [15:0]  pkt_a, pkt_b;
  logic [175:0] pkt_c;
  logic         busy_a, busy_b, busy_c;
  logic         done_a, done_b, done_c;
  logic         valid_a, valid_b, valid_c;
  logic [7:0]   byte_a, byte_b, byte_c;

  packet_printer #(.PACKET_BYTES(2), .HEX_MODE(0), .APPEND_CRLF(0)) u_raw (
    .clk(clk), .rst(rst), .start(start_a), .packet(pkt_a), .busy(busy_a), .done(done_a),
    .tx_byte(byte_a), .tx_valid(valid_a), .tx_ready(rdy_a)
  );

  packet_printer #(.PACKET_BYTES(2), .HEX_MODE(1), .APPEND_CRLF(1)) u_hex (
    .clk(clk), .rst(rst), .start(start_b), .packet(pkt_b), .busy(busy_b), .done(done_b),
    .tx_byte(byte_b), .tx_valid(valid_b), .tx_ready(rdy_b)
  );

  packet_printer u_def (
    .clk(clk), .rst(rst), .start(start_c), .packet(pkt_c), .busy(busy_c), .done(done_c),
    .tx_byte(byte_c), .tx_valid(valid_c), .tx_ready(rdy_c)
  );

  typedef struct {
    int          sel;
    logic        start;
    logic        ready;
    logic [15:0] pkt;
    logic        ev;
    logic [7:0]  eb;
    logic        ebusy;
    logic        edone;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] got[$];
  logic [7:0] exp_s[$];
  int         got_done;
  int         n_vec  = 0;
  int         n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int s, logic st, logic rd, logic [15:0] p,
                              logic ev, logic [7:0] eb, logic ebusy, logic edone);
    vec_t v;
    v.sel = s; v.start = st; v.ready = rd; v.pkt = p;
    v.ev = ev; v.eb = eb; v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  task automatic drive(input int s, input logic st, input logic rd);
    case (s)
      0:       begin start_a = st; rdy_a = rd; end
      1:       begin start_b = st; rdy_b = rd; end
      default: begin start_c = st; rdy_c = rd; end
    endcase
  endtask

  function automatic logic o_valid(int s);
    case (s)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic logic [7:0] o_byte(int s);
    case (s)
      0:       return byte_a;
      1:       return byte_b;
      default: return byte_c;
    endcase
  endfunction

  function automatic logic o_busy(int s);
    case (s)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic o_done(int s);
    case (s)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic [7:0] hexc(logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) r = 8'h30 + {4'h0, n};
    else           r = 8'h37 + {4'h0, n};
    return r;
  endfunction

  // Starts a print with tx_ready held high and records every accepted character.
  task automatic run_print(input int s);
    int after;
    after = 0;
    got.delete();
    got_done = 0;
    @(posedge clk); #1; drive(s, 1'b1, 1'b1);
    @(posedge clk); #1; drive(s, 1'b0, 1'b1);
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (o_valid(s)) got.push_back(o_byte(s));
      if (o_done(s)) got_done++;
      if (got_done > 0) after++;
      if (after > 3) break;
    end
  endtask

  task automatic cmp_stream(input string nm);
    chk($sformatf("%s len", nm), got.size(), exp_s.size());
    for (int j = 0; j < exp_s.size(); j++) begin
      if (j < got.size()) chk($sformatf("%s char%0d", nm, j), got[j], exp_s[j]);
    end
    chk($sformatf("%s done_count", nm), got_done, 1);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    rdy_a = 1; rdy_b = 1; rdy_c = 1;
    pkt_a = 16'h0; pkt_b = 16'h0; pkt_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset%0d valid", s), o_valid(s), 0);
      chk($sformatf("reset%0d byte", s),  o_byte(s),  0);
      chk($sformatf("reset%0d busy", s),  o_busy(s),  0);
      chk($sformatf("reset%0d done", s),  o_done(s),  0);
    end
    @(posedge clk); #1; rst = 1'b0;

    // raw mode: A5, 5A back-to-back, busy for 3 cycles including the done cycle
    tbl.push_back(mk(0, 1, 1, 16'hA55A, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'hA55A, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 1, 16'hA55A, 1, 8'h5A, 1, 0));
    tbl.push_back(mk(0, 0, 1, 16'hA55A, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 0, 1, 16'hA55A, 0, 8'h00, 0, 0));
    // hex+CRLF "3F0C\r\n", 5-cycle stall on 'F', packet changed and start re-pulsed while busy
    tbl.push_back(mk(1, 1, 1, 16'h3F0C, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 1, 8'h33, 1, 0));
    tbl.push_back(mk(1, 1, 0, 16'hFFFF, 1, 8'h46, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'hFFFF, 1, 8'h46, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'hFFFF, 1, 8'h46, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'hFFFF, 1, 8'h46, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'hFFFF, 1, 8'h46, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 1, 8'h46, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 1, 8'h30, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 1, 8'h43, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 1, 8'h0D, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 1, 8'h0A, 1, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 0, 8'h00, 1, 1));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 0, 8'h00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i].sel, tbl[i].start, tbl[i].ready);
      if (tbl[i].sel == 0) pkt_a = tbl[i].pkt;
      else                 pkt_b = tbl[i].pkt;
      @(negedge clk);
      chk($sformatf("v%0d valid", i), o_valid(tbl[i].sel), tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("v%0d byte", i), o_byte(tbl[i].sel), tbl[i].eb);
      chk($sformatf("v%0d busy", i), o_busy(tbl[i].sel), tbl[i].ebusy);
      chk($sformatf("v%0d done", i), o_done(tbl[i].sel), tbl[i].edone);
    end

    // reset during the third character abandons the print without done
    @(posedge clk); #1; pkt_b = 16'h3F0C; drive(1, 1'b1, 1'b1);
    @(posedge clk); #1; drive(1, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("pre_reset byte", byte_b, 8'h30);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_reset valid", valid_b, 0);
    chk("post_reset busy", busy_b, 0);
    chk("post_reset done", done_b, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d done", k), done_b, 0);
    end
    exp_s = '{8'h33, 8'h46, 8'h30, 8'h43, 8'h0D, 8'h0A};
    run_print(1);
    cmp_stream("restart");

    // default config, bytes 0x00..0x15 sent MSB byte first
    for (int i = 0; i < 22; i++) pkt_c[8*i +: 8] = 8'(21 - i);
    exp_s.delete();
    for (int j = 0; j < 22; j++) begin
      exp_s.push_back(hexc(4'(j >> 4)));
      exp_s.push_back(hexc(4'(j)));
    end
    exp_s.push_back(8'h0D);
    exp_s.push_back(8'h0A);
    run_print(2);
    cmp_stream("default");
    if (got.size() >= 4) begin
      chk("default head", {got[0], got[1], got[2], got[3]}, 32'h30303031);
      chk("default tail", {got[got.size()-4], got[got.size()-3], got[got.size()-2], got[got.size()-1]},
          32'h31350D0A);
    end else begin
      chk("default head_len", got.size(), 46);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
